// File: rtl/calc_entry_sequencer_if.sv
// rtl/calc_entry_sequencer_if.sv - keypad, arithmetic-unit handshake and display signal bundle
interface calc_entry_sequencer_if #(
    parameter int DIGITS = 8,
    parameter int OP_W   = 4
);
    // keypad strobes
    logic                  digit_valid;
    logic [3:0]            digit_in;
    logic                  op_valid;
    logic [OP_W-1:0]       op_code;
    logic                  enter;
    logic                  clear;

    // arithmetic unit return path
    logic [4*DIGITS-1:0]   result_in;
    logic                  result_valid;
    logic                  result_err;

    // latched operands and request to the arithmetic unit
    logic [4*DIGITS-1:0]   operand_a;
    logic [4*DIGITS-1:0]   operand_b;
    logic [OP_W-1:0]       op_reg;
    logic                  start_calc;

    // display and status
    logic [4*DIGITS-1:0]   display_value;
    logic                  op_display;
    logic                  entry_full;
    logic                  error;
    logic [2:0]            state;

    // keypad / arithmetic unit / display side
    modport master (
        output digit_valid, digit_in, op_valid, op_code, enter, clear,
        output result_in, result_valid, result_err,
        input  operand_a, operand_b, op_reg, start_calc,
        input  display_value, op_display, entry_full, error, state
    );

    // sequencer side
    modport slave (
        input  digit_valid, digit_in, op_valid, op_code, enter, clear,
        input  result_in, result_valid, result_err,
        output operand_a, operand_b, op_reg, start_calc,
        output display_value, op_display, entry_full, error, state
    );
endinterface

// File: rtl/calc_entry_sequencer.sv
// rtl/calc_entry_sequencer.sv - calculator entry sequencer: operand/operator entry, ALU handshake, display select
module calc_entry_sequencer #(
    parameter int DIGITS      = 8,
    parameter int OP_W        = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    calc_entry_sequencer_if.slave   bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [CW-1:0] CNT_MAX   = CW'(DIGITS);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_NUM1 = 3'd0,
        S_OP   = 3'd1,
        S_NUM2 = 3'd2,
        S_WAIT = 3'd3,
        S_RES  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // the one keypad event that acts this cycle (clear is handled separately)
    typedef enum logic [1:0] {
        K_NONE  = 2'd0,
        K_DIGIT = 2'd1,
        K_OP    = 2'd2,
        K_ENTER = 2'd3
    } key_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [W-1:0]    res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            start_q, start_d;
    logic            full_q, full_d;
    logic [W-1:0]    disp_q, disp_d;

    key_t            key;
    logic            cnt_full;

    // non-BCD digit codes never count as a keypress
    always_comb begin
        key = K_NONE;
        if (bus.enter) begin
            key = K_ENTER;
        end else if (bus.op_valid) begin
            key = K_OP;
        end else if (bus.digit_valid && (bus.digit_in <= 4'd9)) begin
            key = K_DIGIT;
        end
    end

    assign cnt_full = (cnt_q == CNT_MAX);

    // next-state and datapath update for the entry sequence
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        start_d = 1'b0;
        full_d  = 1'b0;

        if (bus.clear) begin
            state_d = S_NUM1;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            res_d   = '0;
            cnt_d   = '0;
            wait_d  = '0;
        end else begin
            case (state_q)
                S_NUM1: begin
                    case (key)
                        K_OP: begin
                            op_d    = bus.op_code;
                            state_d = S_OP;
                        end
                        K_DIGIT: begin
                            if (cnt_full) begin
                                full_d = 1'b1;
                            end else begin
                                a_d   = {a_q[W-5:0], bus.digit_in};
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                S_OP: begin
                    case (key)
                        K_OP: op_d = bus.op_code;
                        K_DIGIT: begin
                            b_d     = {{(W-4){1'b0}}, bus.digit_in};
                            cnt_d   = CW'(1);
                            state_d = S_NUM2;
                        end
                        default: ;
                    endcase
                end
                S_NUM2: begin
                    case (key)
                        K_ENTER: begin
                            if (cnt_q != '0) begin
                                start_d = 1'b1;
                                wait_d  = '0;
                                state_d = S_WAIT;
                            end
                        end
                        K_OP: op_d = bus.op_code;
                        K_DIGIT: begin
                            if (cnt_full) begin
                                full_d = 1'b1;
                            end else begin
                                b_d   = {b_q[W-5:0], bus.digit_in};
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                S_WAIT: begin
                    // a result on the terminal-count cycle still counts
                    if (bus.result_valid && !bus.result_err) begin
                        res_d   = bus.result_in;
                        state_d = S_RES;
                    end else if (bus.result_valid || (wait_q == WAIT_LAST)) begin
                        state_d = S_ERR;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                S_RES: begin
                    case (key)
                        K_DIGIT: begin
                            a_d     = {{(W-4){1'b0}}, bus.digit_in};
                            cnt_d   = CW'(1);
                            state_d = S_NUM1;
                        end
                        K_OP: begin
                            a_d     = res_q;
                            op_d    = bus.op_code;
                            state_d = S_OP;
                        end
                        K_ENTER: begin
                            a_d     = res_q;
                            start_d = 1'b1;
                            wait_d  = '0;
                            state_d = S_WAIT;
                        end
                        default: ;
                    endcase
                end
                S_ERR: ;
                default: state_d = S_NUM1;
            endcase
        end
    end

    // display source follows the state being entered so it changes on the same edge
    always_comb begin
        disp_d = a_d;
        case (state_d)
            S_OP:          disp_d = {{(W-OP_W){1'b0}}, op_d};
            S_NUM2, S_WAIT: disp_d = b_d;
            S_RES:         disp_d = res_d;
            S_ERR:         disp_d = '1;
            default:       disp_d = a_d;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_NUM1;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            start_q <= 1'b0;
            full_q  <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            start_q <= start_d;
            full_q  <= full_d;
            disp_q  <= disp_d;
        end
    end

    assign bus.operand_a     = a_q;
    assign bus.operand_b     = b_q;
    assign bus.op_reg        = op_q;
    assign bus.start_calc    = start_q;
    assign bus.display_value = disp_q;
    assign bus.op_display    = (state_q == S_OP);
    assign bus.entry_full    = full_q;
    assign bus.error         = (state_q == S_ERR);
    assign bus.state         = state_q;
endmodule

// File: tb/tb_calc_entry_sequencer.sv
// tb/tb_calc_entry_sequencer.sv - scoreboard bench for calc_entry_sequencer
module tb_calc_entry_sequencer;
    localparam int DIGITS = 8;
    localparam int OP_W   = 4;
    localparam int TO     = 16;

    // debug state codes, in the order the states are listed
    localparam int P_NUM1 = 0;
    localparam int P_OP   = 1;
    localparam int P_NUM2 = 2;
    localparam int P_WAIT = 3;
    localparam int P_RES  = 4;
    localparam int P_ERR  = 5;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    calc_entry_sequencer_if #(.DIGITS(DIGITS), .OP_W(OP_W)) bus ();

    calc_entry_sequencer #(.DIGITS(DIGITS), .OP_W(OP_W), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          ph;
        logic [31:0] disp;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        bit          start;
        bit          full;
    } exp_t;

    exp_t sbq[$];

    int tests = 0;
    int fails = 0;

    // reference model state
    int          m_ph;
    int          m_cnt;
    int          m_wait;
    logic [31:0] m_a, m_b, m_res;
    logic [3:0]  m_op;
    bit          m_start, m_full;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_disp();
        case (m_ph)
            P_OP:           return {28'h0, m_op};
            P_NUM2, P_WAIT: return m_b;
            P_RES:          return m_res;
            P_ERR:          return 32'hFFFF_FFFF;
            default:        return m_a;
        endcase
    endfunction

    task automatic model_step(input bit rst, clr, ent, opv, dv, input logic [3:0] d, opc,
                              input bit rv, re, input logic [31:0] rin);
        int key;
        m_start = 0;
        m_full  = 0;
        if (rst || clr) begin
            m_ph = P_NUM1; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_cnt = 0; m_wait = 0;
        end else begin
            key = ent ? 3 : opv ? 2 : (dv && d < 10) ? 1 : 0;
            case (m_ph)
                P_NUM1: begin
                    if (key == 2) begin
                        m_op = opc; m_ph = P_OP;
                    end else if (key == 1) begin
                        if (m_cnt == DIGITS) m_full = 1;
                        else begin m_a = m_a * 16 + 32'(d); m_cnt++; end
                    end
                end
                P_OP: begin
                    if (key == 2) m_op = opc;
                    else if (key == 1) begin m_b = 32'(d); m_cnt = 1; m_ph = P_NUM2; end
                end
                P_NUM2: begin
                    if (key == 3) begin
                        if (m_cnt >= 1) begin m_start = 1; m_wait = 0; m_ph = P_WAIT; end
                    end else if (key == 2) m_op = opc;
                    else if (key == 1) begin
                        if (m_cnt == DIGITS) m_full = 1;
                        else begin m_b = m_b * 16 + 32'(d); m_cnt++; end
                    end
                end
                P_WAIT: begin
                    if (rv && !re) begin m_res = rin; m_ph = P_RES; end
                    else if (rv) m_ph = P_ERR;
                    else if (m_wait == TO - 1) m_ph = P_ERR;
                    else m_wait++;
                end
                P_RES: begin
                    if (key == 1) begin m_a = 32'(d); m_cnt = 1; m_ph = P_NUM1; end
                    else if (key == 2) begin m_a = m_res; m_op = opc; m_ph = P_OP; end
                    else if (key == 3) begin m_a = m_res; m_start = 1; m_wait = 0; m_ph = P_WAIT; end
                end
                default: ;
            endcase
        end
    endtask

    // one clock of stimulus: drive at the falling edge, push the model's post-edge expectation
    task automatic cyc(input bit rst, clr, ent, opv, dv, input logic [3:0] d, opc,
                       input bit rv, re, input logic [31:0] rin);
        exp_t e;
        @(negedge clk);
        reset            = rst;
        bus.clear        = clr;
        bus.enter        = ent;
        bus.op_valid     = opv;
        bus.digit_valid  = dv;
        bus.digit_in     = d;
        bus.op_code      = opc;
        bus.result_valid = rv;
        bus.result_err   = re;
        bus.result_in    = rin;
        model_step(rst, clr, ent, opv, dv, d, opc, rv, re, rin);
        e.ph    = m_ph;
        e.disp  = model_disp();
        e.a     = m_a;
        e.b     = m_b;
        e.op    = m_op;
        e.start = m_start;
        e.full  = m_full;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 32'h0);
    endtask
    task automatic key_digit(input logic [3:0] d);
        cyc(0, 0, 0, 0, 1, d, 4'd0, 0, 0, 32'h0);
    endtask
    task automatic key_op(input logic [3:0] c);
        cyc(0, 0, 0, 1, 0, 4'd0, c, 0, 0, 32'h0);
    endtask
    task automatic key_enter();
        cyc(0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 32'h0);
    endtask
    task automatic key_clear();
        cyc(0, 1, 0, 0, 0, 4'd0, 4'd0, 0, 0, 32'h0);
    endtask
    task automatic alu(input logic [31:0] r, input bit err);
        cyc(0, 0, 0, 0, 0, 4'd0, 4'd0, 1, err, r);
    endtask
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // monitor: every registered output is compared against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_state",      32'(bus.state),         32'(e.ph));
                chk("sb_display",    bus.display_value,       e.disp);
                chk("sb_operand_a",  bus.operand_a,           e.a);
                chk("sb_operand_b",  bus.operand_b,           e.b);
                chk("sb_op_reg",     32'(bus.op_reg),         32'(e.op));
                chk("sb_start_calc", 32'(bus.start_calc),     32'(e.start));
                chk("sb_entry_full", 32'(bus.entry_full),     32'(e.full));
                chk("sb_error",      32'(bus.error),          32'(e.ph == P_ERR));
                chk("sb_op_display", 32'(bus.op_display),     32'(e.ph == P_OP));
            end
        end
    end

    // stimulus: directed test-plan sequences, then random traffic
    initial begin
        bit          rst, clr, ent, opv, dv, rv, re;
        logic [3:0]  d, opc;
        logic [31:0] r;

        reset = 1'b1;
        bus.clear = 0; bus.enter = 0; bus.op_valid = 0; bus.digit_valid = 0;
        bus.digit_in = 0; bus.op_code = 0; bus.result_valid = 0; bus.result_err = 0;
        bus.result_in = 0;

        cyc(1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 32'h0);
        cyc(1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 32'h0);
        settle();
        chk("rst_state",   32'(bus.state), P_NUM1);
        chk("rst_display", bus.display_value, 32'h0);
        chk("rst_error",   32'(bus.error), 32'h0);

        key_digit(4'd1); key_digit(4'd2); key_digit(4'd3);
        settle();
        chk("a123_display", bus.display_value, 32'h0000_0123);
        chk("a123_state",   32'(bus.state), P_NUM1);
        key_op(4'd2);
        settle();
        chk("op2_display",    bus.display_value, 32'h0000_0002);
        chk("op2_op_display", 32'(bus.op_display), 32'h1);

        key_digit(4'd4); key_digit(4'd5); key_enter();
        settle();
        chk("enter_start", 32'(bus.start_calc), 32'h1);
        chk("enter_a",     bus.operand_a, 32'h123);
        chk("enter_b",     bus.operand_b, 32'h45);
        idle(1);
        settle();
        chk("start_one_cycle", 32'(bus.start_calc), 32'h0);
        alu(32'h168, 0);
        settle();
        chk("res_display", bus.display_value, 32'h0000_0168);
        chk("res_state",   32'(bus.state), P_RES);

        key_op(4'd1); key_digit(4'd2); key_enter();
        settle();
        chk("chain_start", 32'(bus.start_calc), 32'h1);
        chk("chain_a",     bus.operand_a, 32'h168);
        chk("chain_b",     bus.operand_b, 32'h2);
        alu(32'h170, 0);
        key_enter();
        settle();
        chk("repeat_start", 32'(bus.start_calc), 32'h1);
        chk("repeat_a",     bus.operand_a, 32'h170);
        chk("repeat_b",     bus.operand_b, 32'h2);

        idle(TO - 1);
        settle();
        chk("timeout_not_yet", 32'(bus.state), P_WAIT);
        idle(1);
        settle();
        chk("timeout_state",   32'(bus.state), P_ERR);
        chk("timeout_error",   32'(bus.error), 32'h1);
        chk("timeout_display", bus.display_value, 32'hFFFF_FFFF);
        key_clear();
        settle();
        chk("clr_state",   32'(bus.state), P_NUM1);
        chk("clr_display", bus.display_value, 32'h0);
        chk("clr_a",       bus.operand_a, 32'h0);
        chk("clr_op",      32'(bus.op_reg), 32'h0);
        chk("clr_error",   32'(bus.error), 32'h0);

        repeat (8) key_digit(4'd9);
        settle();
        chk("eight_full", 32'(bus.entry_full), 32'h0);
        key_digit(4'd9);
        settle();
        chk("ninth_full", 32'(bus.entry_full), 32'h1);
        chk("ninth_a",    bus.operand_a, 32'h9999_9999);
        key_digit(4'd12);
        settle();
        chk("bad_digit_full", 32'(bus.entry_full), 32'h0);

        key_clear(); key_digit(4'd5); key_digit(4'd12);
        settle();
        chk("bad_digit_a", bus.operand_a, 32'h5);

        key_op(4'd3); key_digit(4'd7); key_enter();
        cyc(0, 1, 1, 0, 0, 4'd0, 4'd0, 0, 0, 32'h0);
        settle();
        chk("clr_wins_state", 32'(bus.state), P_NUM1);
        chk("clr_wins_start", 32'(bus.start_calc), 32'h0);
        idle(1);
        alu(32'h999, 0);
        settle();
        chk("late_result_state",   32'(bus.state), P_NUM1);
        chk("late_result_display", bus.display_value, 32'h0);

        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            clr = ($urandom_range(0, 63) == 0);
            ent = ($urandom_range(0, 7) == 0);
            opv = ($urandom_range(0, 7) == 0);
            dv  = ($urandom_range(0, 2) == 0);
            d   = 4'($urandom_range(0, 15));
            opc = 4'($urandom_range(0, 15));
            rv  = ($urandom_range(0, 5) == 0);
            re  = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < 8; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
            cyc(rst, clr, ent, opv, dv, d, opc, rv, re, r);
        end

        idle(2);
        repeat (4) @(posedge clk);
        #3;
        chk("sb_drain", 32'(sbq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/calc_entry_sequencer.md
Name: calc_entry_sequencer

Overview:
- Clocked successor to the calculator's combinational display selector.
- Owns the entry sequence internally instead of taking per-operand flags: operand A, then operator, then operand B, then a handshake with the arithmetic unit, then the result.
- Accumulates packed-BCD operands, drives the value shown on the 7-segment BCD path, and supports chaining a result into the next operation.
- Adds entry-length limiting, a result timeout, and an error state.

Parameters:
- DIGITS, 8, number of BCD digits per operand; data width is 4*DIGITS.
- OP_W, 4, operator code width.
- TIMEOUT_CYC, 1024, cycles to wait for result_valid before entering error.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- digit_valid  in  1  one-cycle strobe; a digit key was pressed.
- digit_in  in  4  BCD digit 0-9; values 10-15 are ignored.
- op_valid  in  1  one-cycle strobe; an operator key was pressed.
- op_code  in  OP_W  operator code.
- enter  in  1  one-cycle strobe; "=" key.
- clear  in  1  one-cycle strobe; clear-all.
- result_in  in  4*DIGITS  packed-BCD result from the arithmetic unit.
- result_valid  in  1  result_in is valid this cycle.
- result_err  in  1  arithmetic error (overflow, divide by zero); sampled together with result_valid.
- operand_a  out  4*DIGITS  latched operand A.
- operand_b  out  4*DIGITS  latched operand B.
- op_reg  out  OP_W  latched operator.
- start_calc  out  1  one-cycle request to the arithmetic unit.
- display_value  out  4*DIGITS  value for the BCD display path.
- op_display  out  1  high while the operator is displayed.
- entry_full  out  1  one-cycle pulse when a digit is rejected because the operand is full.
- error  out  1  high in S_ERR.
- state  out  3  current state, for debug.

Behaviour:
- Reset: state=S_NUM1. operand_a, operand_b, op_reg, display_value and the digit counter are all 0. start_calc, op_display, entry_full and error are all 0.
- Event priority within a cycle: reset > clear > enter > op_valid > digit_valid. Only the highest-priority event present acts; the rest are dropped.
- clear: from any state, returns to the reset condition on the next edge. Exception: the wait-counter is also zeroed, and any result_valid arriving later is ignored.
- Digit entry (S_NUM1 acts on operand_a, S_NUM2 on operand_b):
  - A valid digit (0-9) shifts the operand left by 4 and inserts digit_in in the low nibble; the per-operand counter increments.
  - When the counter already equals DIGITS, the operand is unchanged and entry_full pulses for one cycle.
  - A leading 0 counts as a digit.
- S_NUM1: op_valid latches op_reg and moves to S_OP. enter is ignored.
- S_OP: a digit clears operand_b, loads the digit, sets the counter to 1, and moves to S_NUM2. op_valid re-latches op_reg and stays in S_OP. enter is ignored.
- S_NUM2:
  - enter with counter >= 1: start_calc=1 for exactly one cycle (the cycle after the enter edge); move to S_WAIT and zero the wait-counter.
  - op_valid re-latches op_reg and stays in S_NUM2.
- S_WAIT:
  - Inputs other than clear and result_valid are ignored.
  - result_valid with result_err=0: latch result_in into the result register; move to S_RES.
  - result_valid with result_err=1, or wait-counter reaching TIMEOUT_CYC-1 without result_valid: move to S_ERR.
  - result_valid in the same cycle as the timeout terminal count: the result wins.
- S_RES:
  - A digit starts a new calculation: operand_a becomes that digit, the counter is 1, state goes to S_NUM1.
  - op_valid chains: operand_a is set to the result, op_reg is latched, state goes to S_OP.
  - enter repeats the calculation: operand_a is set to the result, operand_b is kept, start_calc pulses, state goes to S_WAIT.
- S_ERR: error=1; only clear or reset exits.
- result_valid outside S_WAIT is ignored.
- display_value is registered and updates on the same edge as the state:
  - S_NUM1 shows operand_a.
  - S_OP shows op_reg zero-extended; op_display=1 only in this state.
  - S_NUM2 shows operand_b.
  - S_WAIT shows operand_b.
  - S_RES shows the result.
  - S_ERR shows all-ones (0xF per nibble, decoded as "E" downstream).
- Latency: a key strobe is visible on display_value 1 cycle later.
- No arithmetic is performed in this block; operands pass through unmodified.

Test Plan:
- Reset, then digits 1,2,3 -> display_value=0x00000123, state=S_NUM1. op_valid with op_code=2 -> display=0x00000002, op_display=1.
- A=123, op=2, B=45, enter -> one start_calc pulse; operand_a=0x123, operand_b=0x45. result_valid with result_in=0x168 two cycles later -> display=0x00000168, state=S_RES.
- Nine digits 9 in S_NUM1 (DIGITS=8) -> operand_a=0x99999999; entry_full pulses once, on the ninth digit only.
- S_RES with result 0x168, op_valid with op=1, digit 2, enter -> operand_a=0x168, operand_b=0x2, start_calc pulses. Separately, enter in S_RES -> start_calc pulses with operand_b unchanged.
- No result_valid for TIMEOUT_CYC cycles (set to 16) -> S_ERR, error=1, display=0xFFFFFFFF. Then clear -> all outputs at reset values.
- In S_WAIT: enter+clear in the same cycle -> clear wins, no start_calc. A digit with value 12 in S_NUM1 -> ignored, operand unchanged. A late result_valid after clear -> ignored.
